// File: rtl/pattern_tx_pkg.sv
// Shared types and widths for the serial pattern transmitter.
package pattern_tx_pkg;

    typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} tx_state_t;

    localparam int PERIOD_W = 8;
    localparam int REPEAT_W = 4;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/flex_counter.sv
// Free-running counter that wraps to 0 after reaching rollover_val.
// rollover_flag marks the terminal count of the current cycle.
module flex_counter #(
    parameter int NUM_BITS = 4
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                clear,
    input  logic                count_enable,
    input  logic [NUM_BITS-1:0] rollover_val,
    output logic [NUM_BITS-1:0] count_out,
    output logic                rollover_flag
);

    logic [NUM_BITS-1:0] r_count;

    assign rollover_flag = (r_count == rollover_val);
    assign count_out     = r_count;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            r_count <= '0;
        else if (clear)
            r_count <= '0;
        else if (count_enable)
            r_count <= rollover_flag ? '0 : r_count + NUM_BITS'(1);
    end

endmodule

// File: rtl/pattern_tx.sv
// Serial pattern transmitter: shifts a latched pattern out MSB-first,
// with stretched bits, repeats and zero gap bits between repeats.
module pattern_tx
    import pattern_tx_pkg::*;
#(
    parameter int PAT_W    = 4,
    parameter int GAP_BITS = 2
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                start,
    input  logic [PAT_W-1:0]    pattern,
    input  logic [PERIOD_W-1:0] bit_period,
    input  logic [REPEAT_W-1:0] repeat_cnt,
    output logic                serial_out,
    output logic                bit_strobe,
    output logic                busy,
    output logic                done
);

    localparam int BCW = max_int(max_int($clog2(PAT_W), $clog2(GAP_BITS)), 1);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(PAT_W - 1);
    localparam logic [BCW-1:0] LAST_GAP = BCW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

    tx_state_t           r_state;
    logic [PAT_W-1:0]    r_shift;
    logic [PAT_W-1:0]    r_pat;
    logic [PERIOD_W-1:0] r_period;
    logic [REPEAT_W-1:0] r_rep;
    logic [BCW-1:0]      r_bitcnt;

    logic                w_busy;
    logic                w_tc;
    logic [PERIOD_W-1:0] w_pcnt;

    assign w_busy = (r_state == SEND) || (r_state == GAP);

    // Timer is held at 0 outside a transmission so every bit starts at count 0.
    flex_counter #(.NUM_BITS(PERIOD_W)) u_timer (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (!w_busy),
        .count_enable  (w_busy),
        .rollover_val  (r_period),
        .count_out     (w_pcnt),
        .rollover_flag (w_tc)
    );

    assign serial_out = (r_state == SEND) && r_shift[PAT_W-1];
    assign bit_strobe = w_busy && (w_pcnt == '0);
    assign busy       = w_busy;
    assign done       = (r_state == DONE);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state  <= IDLE;
            r_shift  <= '0;
            r_pat    <= '0;
            r_period <= '0;
            r_rep    <= '0;
            r_bitcnt <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_shift  <= pattern;
                        r_pat    <= pattern;
                        r_period <= bit_period;
                        r_rep    <= repeat_cnt;
                        r_bitcnt <= '0;
                        r_state  <= SEND;
                    end else begin
                        r_state  <= IDLE;
                    end
                end
                SEND: begin
                    if (w_tc) begin
                        r_shift  <= r_shift << 1;
                        r_bitcnt <= r_bitcnt + BCW'(1);
                        if (r_bitcnt == LAST_BIT) begin
                            r_bitcnt <= '0;
                            if (r_rep == '0) begin
                                r_state <= DONE;
                            end else if (GAP_BITS > 0) begin
                                r_state <= GAP;
                            end else begin
                                // Back-to-back frames: reload without leaving SEND.
                                r_shift <= r_pat;
                                r_rep   <= r_rep - REPEAT_W'(1);
                            end
                        end
                    end
                end
                GAP: begin
                    if (w_tc) begin
                        r_bitcnt <= r_bitcnt + BCW'(1);
                        if (r_bitcnt == LAST_GAP) begin
                            r_bitcnt <= '0;
                            r_shift  <= r_pat;
                            r_rep    <= (r_rep != '0) ? r_rep - REPEAT_W'(1) : '0;
                            r_state  <= SEND;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_tx.sv
// Randomized scoreboard bench for pattern_tx: two instances (GAP_BITS=2 and 0)
// share stimulus; a reference model expands each request into per-cycle outputs.
module tb_pattern_tx;

    localparam int PW = 4;

    logic          clk = 1'b0;
    logic          n_rst;
    logic          start;
    logic [PW-1:0] pattern;
    logic [7:0]    bit_period;
    logic [3:0]    repeat_cnt;
    logic          so0, bs0, by0, dn0;
    logic          so1, bs1, by1, dn1;

    int checks = 0;
    int errors = 0;

    // Expected {serial_out, bit_strobe, busy, done} per cycle, one queue per DUT.
    logic [3:0] q0[$];
    logic [3:0] q1[$];

    bit         det_en = 1'b0;
    logic [3:0] det_hist;
    int         det_cyc, det_n, det_first;

    always #5 clk = ~clk;

    pattern_tx #(.PAT_W(PW), .GAP_BITS(2)) u_dut0 (
        .clk(clk), .n_rst(n_rst), .start(start), .pattern(pattern),
        .bit_period(bit_period), .repeat_cnt(repeat_cnt),
        .serial_out(so0), .bit_strobe(bs0), .busy(by0), .done(dn0)
    );

    pattern_tx #(.PAT_W(PW), .GAP_BITS(0)) u_dut1 (
        .clk(clk), .n_rst(n_rst), .start(start), .pattern(pattern),
        .bit_period(bit_period), .repeat_cnt(repeat_cnt),
        .serial_out(so1), .bit_strobe(bs1), .busy(by1), .done(dn1)
    );

    // Monitor: pops one expectation per DUT per cycle, mid-cycle.
    always @(negedge clk) begin
        if (n_rst) begin
            if (q0.size() > 0) begin
                logic [3:0] e;
                e = q0.pop_front();
                checks++;
                if ({so0, bs0, by0, dn0} !== e) begin
                    errors++;
                    $display("FAIL gap2_outputs t=%0t got %b expected %b", $time, {so0, bs0, by0, dn0}, e);
                end
            end
            if (q1.size() > 0) begin
                logic [3:0] e;
                e = q1.pop_front();
                checks++;
                if ({so1, bs1, by1, dn1} !== e) begin
                    errors++;
                    $display("FAIL gap0_outputs t=%0t got %b expected %b", $time, {so1, bs1, by1, dn1}, e);
                end
            end
            if (det_en) begin
                det_cyc++;
                det_hist = {det_hist[2:0], so1};
                if (det_hist == 4'b1101) begin
                    det_n++;
                    if (det_first == 0) det_first = det_cyc;
                end
            end
        end
    end

    function automatic int busy_len(input int gap, input int bp, input int rc);
        return (rc + 1) * PW * (bp + 1) + rc * gap * (bp + 1);
    endfunction

    task automatic put(input int which, input logic [3:0] v);
        if (which == 0) q0.push_back(v);
        else            q1.push_back(v);
    endtask

    // Reference model: frames of pattern bits, gap zeros between, then one done cycle.
    task automatic push_stream(input int which, input int gap, input logic [PW-1:0] pat,
                               input int bp, input int rc, input int len);
        int n;
        n = 0;
        for (int f = 0; f <= rc; f++) begin
            for (int b = 0; b < PW; b++)
                for (int c = 0; c <= bp; c++) begin
                    put(which, {pat[PW-1-b], c == 0, 1'b1, 1'b0});
                    n++;
                end
            if (f < rc)
                for (int g = 0; g < gap; g++)
                    for (int c = 0; c <= bp; c++) begin
                        put(which, {1'b0, c == 0, 1'b1, 1'b0});
                        n++;
                    end
        end
        put(which, 4'b0001);
        n++;
        while (n < len) begin
            put(which, 4'b0000);
            n++;
        end
    endtask

    task automatic scramble();
        pattern    = PW'($urandom);
        bit_period = 8'($urandom);
        repeat_cnt = 4'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            put(0, 4'b0000);
            put(1, 4'b0000);
        end
    endtask

    // Called mid-cycle; leaves the bench mid-cycle in the gap-2 DUT's done cycle.
    task automatic xact(input logic [PW-1:0] pat, input int bp, input int rc,
                        input bit pulses, input bit det);
        int b1, len;
        start      = 1'b1;
        pattern    = pat;
        bit_period = 8'(bp);
        repeat_cnt = 4'(rc);
        @(posedge clk); #1;
        b1  = busy_len(0, bp, rc);
        len = busy_len(2, bp, rc) + 1;
        push_stream(0, 2, pat, bp, rc, len);
        push_stream(1, 0, pat, bp, rc, len);
        if (det) begin
            det_hist  = 4'b0000;
            det_cyc   = 0;
            det_n     = 0;
            det_first = 0;
            det_en    = 1'b1;
        end
        start = 1'b0;
        scramble();
        for (int i = 1; i < len; i++) begin
            if (pulses && i <= b1 && $urandom_range(0, 3) == 0) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            scramble();
        end
        det_en = 1'b0;
    endtask

    initial begin
        n_rst      = 1'b0;
        start      = 1'b0;
        pattern    = '0;
        bit_period = '0;
        repeat_cnt = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({so0, bs0, by0, dn0, so1, bs1, by1, dn1} !== 8'b0) begin
            errors++;
            $display("FAIL reset_state got %b expected 00000000", {so0, bs0, by0, dn0, so1, bs1, by1, dn1});
        end
        n_rst = 1'b1;
        idle(3);

        // Basic frame, stretched bits with repeats, detector loopback.
        xact(4'b1101, 0, 0, 1'b0, 1'b0);
        idle(2);
        xact(4'b1101, 2, 1, 1'b1, 1'b0);
        idle(1);
        xact(4'b1101, 0, 2, 1'b0, 1'b1);
        checks++;
        if (det_n != 3) begin
            errors++;
            $display("FAIL detect_count got %0d expected 3", det_n);
        end
        checks++;
        if (det_first != 4) begin
            errors++;
            $display("FAIL detect_first_cycle got %0d expected 4", det_first);
        end
        idle(2);

        // Back-to-back transmissions, one done cycle apart.
        for (int k = 0; k < 3; k++) xact(4'b1011, 0, 0, 1'b0, 1'b0);
        idle(2);

        // Boundaries: longest bit period, most repeats.
        xact(4'b1001, 255, 0, 1'b1, 1'b0);
        xact(4'b0111, 0, 15, 1'b1, 1'b0);
        idle(2);

        // Reset mid-frame at the 6th busy cycle: no done, idle afterwards.
        start      = 1'b1;
        pattern    = 4'b1101;
        bit_period = 8'd3;
        repeat_cnt = 4'd0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 5; c++) begin
            put(0, {pattern[PW-1-c/4], c % 4 == 0, 1'b1, 1'b0});
            put(1, {pattern[PW-1-c/4], c % 4 == 0, 1'b1, 1'b0});
        end
        repeat (5) @(posedge clk);
        #1;
        n_rst = 1'b0;
        #1;
        checks++;
        if ({so0, bs0, by0, dn0, so1, bs1, by1, dn1} !== 8'b0) begin
            errors++;
            $display("FAIL midframe_reset got %b expected 00000000", {so0, bs0, by0, dn0, so1, bs1, by1, dn1});
        end
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;
        idle(6);

        // Randomized requests with ignored mid-frame starts and input churn.
        for (int k = 0; k < 30; k++) begin
            int bp, rc;
            bp = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 20) : $urandom_range(0, 2);
            rc = $urandom_range(0, 4);
            xact(PW'($urandom), bp, rc, 1'b1, 1'b0);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end
        idle(3);
        @(posedge clk); #1;

        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d/%0d entries expected 0/0", q0.size(), q1.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pattern_tx.md
# pattern_tx

- Serial pattern transmitter: on a start pulse, latches a PAT_W-bit pattern and shifts it out MSB-first on a single-bit serial line.
- Each bit is held for a programmable number of clock cycles; the pattern repeats a programmable number of times, with GAP_BITS zero bits between repetitions.
- Acts as the stimulus and transmit side for the team's serial sequence detectors (e.g. the 1101 detector); idle line level is 0.

## Interface
- PAT_W, default 4: pattern width in bits (≥2).
- GAP_BITS, default 2: zero bits inserted between repetitions (0 allowed = back-to-back).
- clk  in  1  clock, rising-edge.
- n_rst  in  1  reset, asynchronous, active-low.
- start  in  1  request; sampled only in IDLE or DONE.
- pattern  in  PAT_W  pattern to send, MSB first; latched on accepted start.
- bit_period  in  8  cycles per bit minus one (0 = one cycle per bit); latched on accepted start.
- repeat_cnt  in  4  extra repetitions (total frames = repeat_cnt+1); latched on accepted start.
- serial_out  out  1  serial data; 0 whenever not in SEND.
- bit_strobe  out  1  high in the first cycle of every transmitted bit (pattern and gap bits).
- busy  out  1  high in SEND and GAP.
- done  out  1  one-cycle pulse after the final bit.

## Operation
- States: IDLE, SEND, GAP, DONE.
- IDLE: outputs all 0. start=1 → latch pattern into shift register, latch bit_period and repeat_cnt, clear bit and period counters → SEND.
- SEND: serial_out = shift_reg[PAT_W-1]. Period counter counts 0..bit_period; at terminal count the shift register shifts left (zero fill) and the bit counter increments.
- Last bit of a frame at terminal count:
  - repeats remaining = 0 → DONE.
  - repeats remaining > 0 and GAP_BITS > 0 → GAP.
  - repeats remaining > 0 and GAP_BITS = 0 → reload the pattern, decrement repeats, stay in SEND.
- GAP: serial_out = 0. Sends GAP_BITS bits, each bit_period+1 cycles long. After the last gap bit → reload the pattern, decrement repeats → SEND.
- DONE: done = 1, busy = 0 for exactly one cycle.
  - start=1 in DONE is accepted as in IDLE (→ SEND).
  - Otherwise → IDLE.
- start in SEND or GAP is ignored; latched values are unaffected.
- pattern, bit_period and repeat_cnt changing after acceptance have no effect.
- Widths:
  - Bit counter: $clog2(PAT_W) bits, or $clog2(GAP_BITS) bits if larger.
  - Period counter: 8 bits, compared against the latched bit_period. No wrap beyond 255: bit_period=255 gives 256 cycles per bit.
  - Repeat counter: 4 bits, decrementing and saturating at 0.

## Timing
- Reset (asynchronous): state = IDLE; serial_out, bit_strobe, busy, done = 0; all counters and the shift register cleared. Reset mid-frame aborts immediately with no done pulse.
- Outputs are decoded only from registered state, shift register and counters (Moore); there is no combinational path from any input to any output.
- start sampled at edge k → SEND from cycle k+1. serial_out presents the pattern MSB and bit_strobe = 1 in cycle k+1.
- Frame length: PAT_W·(bit_period+1) cycles. Gap length: GAP_BITS·(bit_period+1) cycles.
- Total busy cycles: (repeat_cnt+1)·PAT_W·(bit_period+1) + repeat_cnt·GAP_BITS·(bit_period+1). done is asserted in the cycle immediately after.
- Back-to-back transmissions: start held high through DONE gives exactly one idle-level (0) cycle between transmissions.

## Structure
- Shared package pattern_tx_pkg holds:
  - typedef enum logic [1:0] tx_state_t {IDLE, SEND, GAP, DONE};
  - localparam PERIOD_W = 8 and REPEAT_W = 4.
- One sub-module: flex_counter, a parameterised-width counter with clear, count_enable, rollover_val and rollover_flag. It is instantiated once as the bit-period timer.
- Bit counter, repeat counter and shift register stay inline in pattern_tx.

## Test plan
- Reset mid-frame: pattern=1101, bit_period=3, n_rst low at the 6th busy cycle → all outputs 0 immediately, no done. After release, IDLE and start required again.
- Basic frame: PAT_W=4, pattern=1101, bit_period=0, repeat_cnt=0, start at edge 0 → serial_out 1,1,0,1 in cycles 1–4, bit_strobe=1 each cycle, busy=1 cycles 1–4, done=1 cycle 5, all 0 cycle 6.
- Stretched bits and repeats: pattern=1101, bit_period=2, repeat_cnt=1, GAP_BITS=2 → each bit held 3 cycles, bit_strobe every 3rd cycle. Sequence 1101 00 1101 over 30 busy cycles; done in cycle 31.
- Ignored start and latched inputs: start pulsed and pattern changed to 0010 mid-frame → transmitted bits unchanged, no restart.
- Back-to-back: start held high continuously, repeat_cnt=0, bit_period=0 → frames of 4 bits separated by exactly one DONE cycle with serial_out=0. done pulses every 5 cycles.
- Loopback into the 1101 sequence detector: repeat_cnt=2, GAP_BITS=0, bit_period=0 → detector output high once per frame, 3 detections total, first in cycle 5 after start.
